fft_stream_framer: RTL and testbench
====================================

Name: fft_stream_framer

Overview:
- Avalon-ST source-side framer in front of the FFT core.
- Takes an unframed sample stream and cuts it into FFT-length packets, generating startofpacket and endofpacket from an internal sample counter.
- Appends a per-packet inverse/forward flag as the data LSB.
- Run-time configured through a small Avalon-MM CSR. Output is registered through a 2-entry skid buffer, so full throughput is kept under backpressure.

Parameters:
SYMBOL_WIDTH, 32, input sample width in bits; output data is SYMBOL_WIDTH+1 bits.
MAX_LOG2_LEN, 12, largest supported FFT length as log2 (N_max = 2^MAX_LOG2_LEN).
DEFAULT_INVERSE, 0, reset value of CTRL.inverse.

Ports:
csi_clk  in  1  sole clock.
rsi_reset  in  1  synchronous, active-high reset.
asi_in_data  in  SYMBOL_WIDTH  input sample.
asi_in_valid  in  1  input sample valid.
asi_in_ready  out  1  input may transfer this cycle.
aso_out_data  out  SYMBOL_WIDTH+1  {sample, inverse_flag}; the flag is bit 0.
aso_out_valid  out  1  output beat valid.
aso_out_startofpacket  out  1  first beat of a frame.
aso_out_endofpacket  out  1  last beat of a frame.
aso_out_ready  in  1  downstream ready; Avalon-ST ready latency 0.
avs_csr_address  in  2  register select.
avs_csr_write  in  1  write strobe.
avs_csr_writedata  in  32  write data.
avs_csr_read  in  1  read strobe.
avs_csr_readdata  out  32  read data, valid 1 cycle after avs_csr_read.

Behaviour:

CSR map (a write takes effect on the following cycle):
- 0 CTRL, RW: bit0 inverse, bit1 enable.
- 1 LOG2LEN, RW: bits[4:0]. A written value is clamped to the range [3, MAX_LOG2_LEN].
- 2 PKTCNT, RO: bits[15:0] count of completed output frames; wraps from 0xFFFF to 0.
- 3 POS, RO: current input sample position within the frame.
- Unused bits read 0. Writes to addresses 2 and 3 are ignored.

Reset (rsi_reset high at a clock edge):
- All outputs go to 0, including avs_csr_readdata.
- CTRL = {enable=0, inverse=DEFAULT_INVERSE}; LOG2LEN = MAX_LOG2_LEN.
- PKTCNT = 0, POS = 0, skid buffer emptied.
- Reset mid-frame discards the partial frame with no eop emitted.

Input acceptance:
- Accept is asi_in_valid && asi_in_ready.
- asi_in_ready = run && !skid_full.
- run: when POS==0, run = CTRL.enable; when POS!=0, run = 1. An enable cleared mid-frame therefore takes effect only after the in-flight frame completes.

Frame latching:
- On an accept with POS==0, the block latches frame_inv = CTRL.inverse and frame_len = 2^LOG2LEN.
- Both are held for the whole frame. CSR changes mid-frame apply to the next frame only.
- If a CSR write and a frame-start accept happen in the same cycle, the frame uses the pre-write values.

Position counter:
- POS increments on every accept.
- On an accept with POS == frame_len-1, POS wraps to 0.
- Each accepted beat carries sop = (POS==0) and eop = (POS==frame_len-1).

Output stage:
- Accepted beat = {asi_in_data, frame_inv} plus its sop and eop.
- The beat enters the output register and appears on aso_out_* exactly 1 cycle after accept when the output stage is empty or draining.
- Skid buffer holds 2 entries and is strictly in-order.
- aso_out_valid is held, with data/sop/eop stable, until aso_out_ready.
- An accept and an output transfer in the same cycle with 1 entry held keeps occupancy at 1. Sustained 1 beat/cycle is required when aso_out_ready stays high.
- skid_full means 2 entries are held. asi_in_ready deasserts combinationally from registered state only; there is no combinational path from aso_out_ready to asi_in_ready.

PKTCNT: increments when a beat with eop=1 transfers on the output. This is counted at output, not at input.

Test Plan:
- Reset, write CTRL=0x2 (enable, forward) and LOG2LEN=3, send 16 samples 0..15 with aso_out_ready=1 → two 8-beat frames; sop on samples 0 and 8, eop on samples 7 and 15; data = sample<<1; first output 1 cycle after first accept; PKTCNT reads 2.
- During the 4th sample of a frame write CTRL=0x3 → that frame keeps bit0=0; the next frame has bit0=1 on all 8 beats.
- Write LOG2LEN=1 → reads back 3. Write LOG2LEN=31 with MAX_LOG2_LEN=12 → reads back 12.
- Random aso_out_ready (50%) with continuous input → no beat lost, duplicated or reordered. asi_in_ready goes low only when 2 beats are buffered. sop/eop positions are unchanged.
- Clear enable at POS=5 of an 8-beat frame → the remaining 3 samples are still accepted and eop is emitted; then asi_in_ready=0 and POS=0.
- Assert rsi_reset at POS=4 → outputs go to 0, POS=0, PKTCNT=0, no eop emitted. After re-enable the next accepted sample carries sop.

Source files
------------

// File: rtl/fft_stream_framer.sv
// Avalon-ST framer ahead of the FFT core: slices an unframed sample stream into
// power-of-two packets, tags each beat with the frame's inverse flag, and exposes a small CSR.
module fft_stream_framer #(
    parameter int unsigned SYMBOL_WIDTH    = 32,
    parameter int unsigned MAX_LOG2_LEN    = 12,
    parameter bit          DEFAULT_INVERSE = 1'b0
) (
    input  logic                    csi_clk,
    input  logic                    rsi_reset,
    input  logic [SYMBOL_WIDTH-1:0] asi_in_data,
    input  logic                    asi_in_valid,
    output logic                    asi_in_ready,
    output logic [SYMBOL_WIDTH:0]   aso_out_data,
    output logic                    aso_out_valid,
    output logic                    aso_out_startofpacket,
    output logic                    aso_out_endofpacket,
    input  logic                    aso_out_ready,
    input  logic [1:0]              avs_csr_address,
    input  logic                    avs_csr_write,
    input  logic [31:0]             avs_csr_writedata,
    input  logic                    avs_csr_read,
    output logic [31:0]             avs_csr_readdata
);

    localparam int unsigned DW    = SYMBOL_WIDTH + 1;
    localparam int unsigned BW    = DW + 2;
    localparam int unsigned POS_W = MAX_LOG2_LEN;
    localparam int unsigned LEN_W = 5;
    localparam logic [LEN_W-1:0] MIN_LOG2 = LEN_W'(3);
    localparam logic [LEN_W-1:0] MAX_LOG2 = LEN_W'(MAX_LOG2_LEN);

    localparam logic [1:0] ADDR_CTRL    = 2'd0;
    localparam logic [1:0] ADDR_LOG2LEN = 2'd1;
    localparam logic [1:0] ADDR_PKTCNT  = 2'd2;
    localparam logic [1:0] ADDR_POS     = 2'd3;

    logic             ctrl_inv_q,   ctrl_inv_d;
    logic             ctrl_en_q,    ctrl_en_d;
    logic [LEN_W-1:0] log2len_q,    log2len_d;
    logic [15:0]      pktcnt_q,     pktcnt_d;
    logic [POS_W-1:0] pos_q,        pos_d;
    logic             frame_inv_q,  frame_inv_d;
    logic [POS_W-1:0] frame_last_q, frame_last_d;
    logic [BW-1:0]    ent0_q,       ent0_d;
    logic [BW-1:0]    ent1_q,       ent1_d;
    logic             v0_q,         v0_d;
    logic             v1_q,         v1_d;
    logic [31:0]      rdata_q,      rdata_d;

    logic             run_c;
    logic             in_ready_c;
    logic             accept_c;
    logic             pop_c;
    logic             frame_start_c;
    logic [POS_W:0]   len_full_c;
    logic [POS_W-1:0] new_last_c;
    logic [POS_W-1:0] eff_last_c;
    logic             eff_inv_c;
    logic             eop_c;
    logic [BW-1:0]    beat_c;
    logic [LEN_W-1:0] wr_log2_c;
    logic [26:0]      wdata_unused_c;

    assign wdata_unused_c = avs_csr_writedata[31:5];

    // Frames in flight finish even if enable drops; ready depends on registered state only.
    assign run_c         = (pos_q == '0) ? ctrl_en_q : 1'b1;
    assign in_ready_c    = run_c && !v1_q;
    assign accept_c      = asi_in_valid && in_ready_c;
    assign pop_c         = v0_q && aso_out_ready;
    assign frame_start_c = (pos_q == '0);

    assign len_full_c = (POS_W+1)'(1) << log2len_q;
    assign new_last_c = POS_W'(len_full_c - (POS_W+1)'(1));
    assign eff_last_c = frame_start_c ? new_last_c : frame_last_q;
    assign eff_inv_c  = frame_start_c ? ctrl_inv_q : frame_inv_q;
    assign eop_c      = (pos_q == eff_last_c);
    assign beat_c     = {asi_in_data, eff_inv_c, frame_start_c, eop_c};

    always_comb begin
        wr_log2_c = avs_csr_writedata[LEN_W-1:0];
        if (wr_log2_c < MIN_LOG2) begin
            wr_log2_c = MIN_LOG2;
        end else if (wr_log2_c > MAX_LOG2) begin
            wr_log2_c = MAX_LOG2;
        end
    end

    // CSR writes, read mux and packet counter
    always_comb begin
        ctrl_inv_d = ctrl_inv_q;
        ctrl_en_d  = ctrl_en_q;
        log2len_d  = log2len_q;
        pktcnt_d   = pktcnt_q;
        rdata_d    = rdata_q;

        if (avs_csr_write) begin
            case (avs_csr_address)
                ADDR_CTRL: begin
                    ctrl_inv_d = avs_csr_writedata[0];
                    ctrl_en_d  = avs_csr_writedata[1];
                end
                ADDR_LOG2LEN: log2len_d = wr_log2_c;
                default: ;
            endcase
        end

        if (avs_csr_read) begin
            case (avs_csr_address)
                ADDR_CTRL:    rdata_d = {30'd0, ctrl_en_q, ctrl_inv_q};
                ADDR_LOG2LEN: rdata_d = 32'(log2len_q);
                ADDR_PKTCNT:  rdata_d = 32'(pktcnt_q);
                ADDR_POS:     rdata_d = 32'(pos_q);
                default:      rdata_d = 32'd0;
            endcase
        end

        if (pop_c && ent0_q[0]) begin
            pktcnt_d = pktcnt_q + 16'd1;
        end
    end

    // Frame position and per-frame latched parameters
    always_comb begin
        pos_d        = pos_q;
        frame_inv_d  = frame_inv_q;
        frame_last_d = frame_last_q;

        if (accept_c) begin
            pos_d = eop_c ? '0 : pos_q + POS_W'(1);
            if (frame_start_c) begin
                frame_inv_d  = ctrl_inv_q;
                frame_last_d = new_last_c;
            end
        end
    end

    // Two-entry in-order skid buffer; ent0 is the output register
    always_comb begin
        ent0_d = ent0_q;
        ent1_d = ent1_q;
        v0_d   = v0_q;
        v1_d   = v1_q;

        if (pop_c) begin
            if (v1_q) begin
                ent0_d = ent1_q;
                v1_d   = 1'b0;
            end else if (accept_c) begin
                ent0_d = beat_c;
            end else begin
                v0_d = 1'b0;
            end
        end else if (accept_c) begin
            if (!v0_q) begin
                ent0_d = beat_c;
                v0_d   = 1'b1;
            end else begin
                ent1_d = beat_c;
                v1_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge csi_clk) begin
        if (rsi_reset) begin
            ctrl_inv_q   <= DEFAULT_INVERSE;
            ctrl_en_q    <= 1'b0;
            log2len_q    <= MAX_LOG2;
            pktcnt_q     <= '0;
            pos_q        <= '0;
            frame_inv_q  <= 1'b0;
            frame_last_q <= '0;
            ent0_q       <= '0;
            ent1_q       <= '0;
            v0_q         <= 1'b0;
            v1_q         <= 1'b0;
            rdata_q      <= '0;
        end else begin
            ctrl_inv_q   <= ctrl_inv_d;
            ctrl_en_q    <= ctrl_en_d;
            log2len_q    <= log2len_d;
            pktcnt_q     <= pktcnt_d;
            pos_q        <= pos_d;
            frame_inv_q  <= frame_inv_d;
            frame_last_q <= frame_last_d;
            ent0_q       <= ent0_d;
            ent1_q       <= ent1_d;
            v0_q         <= v0_d;
            v1_q         <= v1_d;
            rdata_q      <= rdata_d;
        end
    end

    assign asi_in_ready          = in_ready_c;
    assign aso_out_valid         = v0_q;
    assign aso_out_data          = ent0_q[BW-1:2];
    assign aso_out_startofpacket = ent0_q[1];
    assign aso_out_endofpacket   = ent0_q[0];
    assign avs_csr_readdata      = rdata_q;

endmodule

// File: tb/tb_fft_stream_framer.sv
// Scoreboard bench for fft_stream_framer: driver pushes expected beats on accept,
// a negedge monitor pops and compares on every output transfer.
module tb_fft_stream_framer;

    localparam int unsigned SW = 32;
    localparam int unsigned BW = SW + 3;

    logic          clk;
    logic          rsi_reset;
    logic [SW-1:0] asi_in_data;
    logic          asi_in_valid;
    logic          asi_in_ready;
    logic [SW:0]   aso_out_data;
    logic          aso_out_valid;
    logic          aso_out_startofpacket;
    logic          aso_out_endofpacket;
    logic          aso_out_ready;
    logic [1:0]    avs_csr_address;
    logic          avs_csr_write;
    logic [31:0]   avs_csr_writedata;
    logic          avs_csr_read;
    logic [31:0]   avs_csr_readdata;

    fft_stream_framer #(
        .SYMBOL_WIDTH   (SW),
        .MAX_LOG2_LEN   (12),
        .DEFAULT_INVERSE(1'b0)
    ) dut (
        .csi_clk              (clk),
        .rsi_reset            (rsi_reset),
        .asi_in_data          (asi_in_data),
        .asi_in_valid         (asi_in_valid),
        .asi_in_ready         (asi_in_ready),
        .aso_out_data         (aso_out_data),
        .aso_out_valid        (aso_out_valid),
        .aso_out_startofpacket(aso_out_startofpacket),
        .aso_out_endofpacket  (aso_out_endofpacket),
        .aso_out_ready        (aso_out_ready),
        .avs_csr_address      (avs_csr_address),
        .avs_csr_write        (avs_csr_write),
        .avs_csr_writedata    (avs_csr_writedata),
        .avs_csr_read         (avs_csr_read),
        .avs_csr_readdata     (avs_csr_readdata)
    );

    int total = 0;
    int bad   = 0;

    logic [BW-1:0] exp_q[$];
    bit  rand_en = 0;
    bit  chk_occ = 0;
    int  occ     = 0;

    // Bench-side model of CSR and framing
    bit  b_inv   = 0;
    int  b_log2  = 12;
    bit  m_inv   = 0;
    int  m_pos   = 0;
    int  m_last  = 0;
    int  exp_pkt = 0;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        aso_out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            aso_out_ready = rand_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "global timeout");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Output monitor and occupancy tracker
    always @(negedge clk) begin
        logic [BW-1:0] e;
        logic [BW-1:0] a;
        if (rsi_reset) begin
            occ = 0;
        end else begin
            if (chk_occ && asi_in_valid && !asi_in_ready) begin
                total++;
                if (occ != 2) begin
                    bad++;
                    $display("FAIL ready_low_occ: got occ=%0d want 2", occ);
                end
            end
            if (aso_out_valid && aso_out_ready) begin
                total++;
                a = {aso_out_data, aso_out_startofpacket, aso_out_endofpacket};
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_beat: got %0h want none", a);
                end else begin
                    e = exp_q.pop_front();
                    if (a !== e) begin
                        bad++;
                        $display("FAIL beat: got %0h want %0h", a, e);
                    end
                end
            end
            occ = occ + ((asi_in_valid && asi_in_ready) ? 1 : 0)
                      - ((aso_out_valid && aso_out_ready) ? 1 : 0);
        end
    end

    function automatic int clamp_log2(input logic [31:0] d);
        int v;
        v = int'(d[4:0]);
        if (v < 3) v = 3;
        if (v > 12) v = 12;
        return v;
    endfunction

    task automatic model_write(input logic [1:0] a, input logic [31:0] d);
        if (a == 2'd0) b_inv = d[0];
        else if (a == 2'd1) b_log2 = clamp_log2(d);
    endtask

    task automatic model_accept(input logic [SW-1:0] s);
        bit sop;
        bit eop;
        if (m_pos == 0) begin
            m_inv  = b_inv;
            m_last = (1 << b_log2) - 1;
        end
        sop = (m_pos == 0);
        eop = (m_pos == m_last);
        exp_q.push_back({s, m_inv, sop, eop});
        if (eop) begin
            m_pos = 0;
            exp_pkt++;
        end else begin
            m_pos++;
        end
    endtask

    task automatic csr_write(input logic [1:0] a, input logic [31:0] d);
        avs_csr_write     = 1'b1;
        avs_csr_address   = a;
        avs_csr_writedata = d;
        @(posedge clk);
        #1;
        avs_csr_write = 1'b0;
        model_write(a, d);
    endtask

    task automatic csr_read(input logic [1:0] a, output logic [31:0] v);
        avs_csr_read    = 1'b1;
        avs_csr_address = a;
        @(posedge clk);
        #1;
        avs_csr_read = 1'b0;
        v = avs_csr_readdata;
    endtask

    task automatic csr_check(input string nm, input logic [1:0] a, input logic [31:0] exp);
        logic [31:0] v;
        csr_read(a, v);
        chk(nm, 64'(v), 64'(exp));
    endtask

    // One sample, optionally with a CSR write issued in the same cycle
    task automatic send(input logic [SW-1:0] s, input bit wr, input logic [1:0] a,
                        input logic [31:0] d);
        bit done;
        done          = 0;
        asi_in_valid  = 1'b1;
        asi_in_data   = s;
        if (wr) begin
            avs_csr_write     = 1'b1;
            avs_csr_address   = a;
            avs_csr_writedata = d;
        end
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge clk);
            if (asi_in_ready) begin
                model_accept(s);
                done = 1;
            end
            if (k == 0 && wr) model_write(a, d);
            @(posedge clk);
            #1;
            avs_csr_write = 1'b0;
        end
        asi_in_valid = 1'b0;
        if (!done) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got no accept want accept of %0h", s);
        end
    endtask

    task automatic drain();
        bit ok;
        ok = 0;
        for (int k = 0; k < 400 && !ok; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !aso_out_valid) ok = 1;
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
    endtask

    task automatic check_reset_outputs(input string nm);
        chk({nm, "_valid"}, 64'(aso_out_valid), 64'(0));
        chk({nm, "_sop"},   64'(aso_out_startofpacket), 64'(0));
        chk({nm, "_eop"},   64'(aso_out_endofpacket), 64'(0));
        chk({nm, "_data"},  64'(aso_out_data), 64'(0));
        chk({nm, "_rdata"}, 64'(avs_csr_readdata), 64'(0));
        chk({nm, "_ready"}, 64'(asi_in_ready), 64'(0));
    endtask

    initial begin
        rsi_reset         = 1'b1;
        asi_in_valid      = 1'b0;
        asi_in_data       = '0;
        avs_csr_address   = 2'd0;
        avs_csr_write     = 1'b0;
        avs_csr_writedata = '0;
        avs_csr_read      = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        rsi_reset = 1'b0;
        csr_check("rst_ctrl", 2'd0, 32'h0);
        csr_check("rst_log2len", 2'd1, 32'd12);
        csr_check("rst_pktcnt", 2'd2, 32'd0);
        csr_check("rst_pos", 2'd3, 32'd0);

        // Two 8-beat forward frames at full rate
        csr_write(2'd0, 32'h2);
        csr_write(2'd1, 32'd3);
        csr_check("log2len_3", 2'd1, 32'd3);
        send(32'd0, 0, 2'd0, 32'd0);
        chk("lat_valid", 64'(aso_out_valid), 64'(1));
        chk("lat_sop", 64'(aso_out_startofpacket), 64'(1));
        chk("lat_data", 64'(aso_out_data), 64'(0));
        for (int i = 1; i < 16; i++) send(SW'(i), 0, 2'd0, 32'd0);
        drain();
        csr_check("pktcnt_2", 2'd2, 32'd2);

        // Inverse change mid-frame and at a frame-start accept
        for (int i = 0; i < 24; i++) begin
            if (i == 3)       send(SW'(16 + i), 1, 2'd0, 32'h3);
            else if (i == 16) send(SW'(16 + i), 1, 2'd0, 32'h2);
            else              send(SW'(16 + i), 0, 2'd0, 32'd0);
        end
        drain();
        csr_check("pktcnt_5", 2'd2, 32'd5);

        // LOG2LEN clamping
        csr_write(2'd1, 32'd1);
        csr_check("log2len_lo_clamp", 2'd1, 32'd3);
        csr_write(2'd1, 32'd31);
        csr_check("log2len_hi_clamp", 2'd1, 32'd12);
        csr_write(2'd1, 32'd3);
        csr_write(2'd2, 32'hFFFF);
        csr_check("pktcnt_ro", 2'd2, 32'd5);

        // Random backpressure with continuous input
        rand_en = 1;
        chk_occ = 1;
        for (int i = 0; i < 40; i++) send(SW'(100 + i), 0, 2'd0, 32'd0);
        rand_en = 0;
        chk_occ = 0;
        drain();
        csr_check("pktcnt_10", 2'd2, 32'd10);

        // Enable cleared at POS=5 lets the frame finish
        for (int i = 0; i < 8; i++) begin
            if (i == 5) send(SW'(200 + i), 1, 2'd0, 32'h0);
            else        send(SW'(200 + i), 0, 2'd0, 32'd0);
        end
        chk("dis_ready", 64'(asi_in_ready), 64'(0));
        asi_in_valid = 1'b1;
        asi_in_data  = SW'(999);
        repeat (3) begin
            @(negedge clk);
            chk("dis_ready_held", 64'(asi_in_ready), 64'(0));
        end
        @(posedge clk);
        #1;
        asi_in_valid = 1'b0;
        csr_check("dis_pos", 2'd3, 32'd0);
        drain();
        csr_check("pktcnt_11", 2'd2, 32'd11);

        // Reset in the middle of a frame
        csr_write(2'd0, 32'h2);
        for (int i = 0; i < 4; i++) send(SW'(300 + i), 0, 2'd0, 32'd0);
        csr_check("pre_rst_pos", 2'd3, 32'd4);
        rsi_reset = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outputs("midrst");
        exp_q.delete();
        b_inv   = 0;
        b_log2  = 12;
        m_pos   = 0;
        exp_pkt = 0;
        rsi_reset = 1'b0;
        csr_check("midrst_pos", 2'd3, 32'd0);
        csr_check("midrst_pktcnt", 2'd2, 32'd0);
        csr_check("midrst_log2len", 2'd1, 32'd12);
        csr_write(2'd0, 32'h2);
        csr_write(2'd1, 32'd3);
        for (int i = 0; i < 8; i++) send(SW'(400 + i), 0, 2'd0, 32'd0);
        drain();
        csr_check("post_rst_pktcnt", 2'd2, 32'(exp_pkt));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
